// File: rtl/ec_pkg.sv
// ec_pkg: types and width helpers shared by the erasure-coding engine blocks.
//
// Contents:
//   EC_W, EC_PACKET_LENGTH : engine-wide defaults (Galois word width, packet width)
//   packet_t               : one packet of XOR data
//   acc_state_t            : parity accumulator FSM states
//   chunk_w / idx_w        : counter width helpers for the parity accumulator
package ec_pkg;

    localparam int EC_W             = 4;
    localparam int EC_PACKET_LENGTH = 2;

    typedef logic [EC_PACKET_LENGTH-1:0] packet_t;

    // ACC_IDLE: no partial packet held; ACC_RUN: partial packet held in acc.
    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    // Chunk counter must cover K_MAX/INPUT_NUM chunks plus headroom.
    function automatic int chunk_w(input int k_max, input int input_num);
        return $clog2(k_max / input_num + 2);
    endfunction

    // Parity index counter covers 0..M_MAX.
    function automatic int idx_w(input int m_max);
        return $clog2(m_max + 1);
    endfunction

endpackage

// File: rtl/parity_accumulator.sv
// parity_accumulator: folds per-chunk XOR products from the XOR tree into a
// running accumulator and emits one parity packet per cfg_chunks beats,
// tagged with its parity index within the stripe.
//
// Optional feature macro: EC_PARITY_STATS_EN (adds stat_parity_cnt and
// stat_stall_cnt outputs; datapath is unchanged).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all job state and outputs
//   cfg_chunks        chunks per parity packet (0 treated as 1)
//   cfg_m             parity packets per stripe (0 treated as 1)
//   in_valid/in_ready input beat handshake, xor_product is the beat data
//   out_valid/out_ready output handshake
//   out_parity        finished parity packet
//   out_idx           parity index 0..m-1
//   out_stripe_end    high with the last parity of a stripe
//   stat_parity_cnt   (EC_PARITY_STATS_EN) handshaken outputs, wraps at 2^32
//   stat_stall_cnt    (EC_PARITY_STATS_EN) cycles with in_valid && !in_ready
//   dbg_state         current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and data stable until the transfer;
// ready may depend combinationally on valid-side state but valid never
// depends on ready.
module parity_accumulator
    import ec_pkg::*;
#(
    parameter  int K_MAX         = 128,
    parameter  int M_MAX         = 128,
    parameter  int PACKET_LENGTH = EC_PACKET_LENGTH,
    parameter  int INPUT_NUM     = 12,
    localparam int CHUNK_W       = chunk_w(K_MAX, INPUT_NUM),
    localparam int IDX_W         = idx_w(M_MAX)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [CHUNK_W-1:0]       cfg_chunks,
    input  logic [IDX_W-1:0]         cfg_m,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PACKET_LENGTH-1:0] xor_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PACKET_LENGTH-1:0] out_parity,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_stripe_end,
`ifdef EC_PARITY_STATS_EN
    output logic [31:0]              stat_parity_cnt,
    output logic [31:0]              stat_stall_cnt,
`endif
    output acc_state_t               dbg_state
);

    acc_state_t               state_q, state_d;
    logic [CHUNK_W-1:0]       chunks_q;
    logic [CHUNK_W-1:0]       chunk_cnt;
    logic [IDX_W-1:0]         idx_cnt;
    logic [IDX_W-1:0]         m_q;
    logic [PACKET_LENGTH-1:0] acc;

    logic [CHUNK_W-1:0]       cfg_chunks_eff;
    logic [IDX_W-1:0]         cfg_m_eff;
    logic [IDX_W-1:0]         stripe_m;
    logic                     is_last;
    logic                     accept;
    logic                     last_fire;
    logic                     out_fire;

    assign cfg_chunks_eff = (cfg_chunks == '0) ? CHUNK_W'(1) : cfg_chunks;
    assign cfg_m_eff      = (cfg_m == '0) ? IDX_W'(1) : cfg_m;

    // At the stripe latch point m_q is being loaded this very cycle, so a
    // single-chunk packet must see the incoming cfg_m for its stripe_end.
    assign stripe_m = (state_q == ACC_IDLE && idx_cnt == '0) ? cfg_m_eff : m_q;

    assign accept    = in_valid && in_ready;
    assign last_fire = accept && is_last;
    assign out_fire  = out_valid && out_ready;
    assign dbg_state = state_q;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC_IDLE;
        end else if (flush) begin
            state_q <= ACC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = is_last ? ACC_IDLE : ACC_RUN;
        end
    end

    // FSM: outputs. Only a last beat needs the output register, so only a
    // last beat can be stalled by a full, unaccepted output.
    always_comb begin
        is_last = 1'b0;
        if (state_q == ACC_IDLE) begin
            is_last = (cfg_chunks_eff == CHUNK_W'(1));
        end else begin
            is_last = (chunk_cnt == chunks_q - CHUNK_W'(1));
        end
        in_ready = !is_last || !out_valid || out_ready;
    end

    // Accumulator and job counters. acc is zero in ACC_IDLE, so the same
    // XOR covers the first beat of a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunks_q  <= '0;
            chunk_cnt <= '0;
            idx_cnt   <= '0;
            m_q       <= '0;
            acc       <= '0;
        end else if (flush) begin
            chunks_q  <= '0;
            chunk_cnt <= '0;
            idx_cnt   <= '0;
            m_q       <= '0;
            acc       <= '0;
        end else if (accept) begin
            if (state_q == ACC_IDLE) begin
                chunks_q <= cfg_chunks_eff;
                if (idx_cnt == '0) begin
                    m_q <= cfg_m_eff;
                end
            end
            if (is_last) begin
                acc       <= '0;
                chunk_cnt <= '0;
                idx_cnt   <= (idx_cnt == stripe_m - IDX_W'(1)) ? '0 : idx_cnt + IDX_W'(1);
            end else begin
                acc       <= acc ^ xor_product;
                chunk_cnt <= chunk_cnt + CHUNK_W'(1);
            end
        end
    end

    // Output register: a reload wins over the clear so a simultaneous
    // accept and new last beat keeps out_valid high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_parity     <= '0;
            out_idx        <= '0;
            out_stripe_end <= 1'b0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            out_parity     <= '0;
            out_idx        <= '0;
            out_stripe_end <= 1'b0;
        end else if (last_fire) begin
            out_valid      <= 1'b1;
            out_parity     <= acc ^ xor_product;
            out_idx        <= idx_cnt;
            out_stripe_end <= (idx_cnt == stripe_m - IDX_W'(1));
        end else if (out_fire) begin
            out_valid      <= 1'b0;
            out_parity     <= '0;
            out_idx        <= '0;
            out_stripe_end <= 1'b0;
        end
    end

`ifdef EC_PARITY_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_parity_cnt <= '0;
            stat_stall_cnt  <= '0;
        end else if (flush) begin
            stat_parity_cnt <= '0;
            stat_stall_cnt  <= '0;
        end else begin
            if (out_fire) begin
                stat_parity_cnt <= stat_parity_cnt + 32'd1;
            end
            if (in_valid && !in_ready) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parity_accumulator.sv
module tb_parity_accumulator;
    import ec_pkg::*;

    localparam int CHUNK_W = chunk_w(128, 12);
    localparam int IDX_W   = idx_w(128);

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [CHUNK_W-1:0] cfg_chunks;
    logic [IDX_W-1:0]   cfg_m;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         xor_product;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_parity;
    logic [IDX_W-1:0]   out_idx;
    logic               out_stripe_end;
`ifdef EC_PARITY_STATS_EN
    logic [31:0]        stat_parity_cnt;
    logic [31:0]        stat_stall_cnt;
`endif
    acc_state_t         dbg_state;

    int total = 0;
    int bad   = 0;

    parity_accumulator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .cfg_chunks     (cfg_chunks),
        .cfg_m          (cfg_m),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .xor_product    (xor_product),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_parity     (out_parity),
        .out_idx        (out_idx),
        .out_stripe_end (out_stripe_end),
`ifdef EC_PARITY_STATS_EN
        .stat_parity_cnt(stat_parity_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .dbg_state      (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b0;
        step();
        flush    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] par, input int idx, input logic se);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_parity"}, 32'(out_parity), 32'(par));
        check({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check({tag, "_end"}, 32'(out_stripe_end), 32'(se));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_parity"}, 32'(out_parity), 32'd0);
        check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
        check({tag, "_out_end"}, 32'(out_stripe_end), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ACC_IDLE));
    endtask

    initial begin
        logic [1:0] t2_data [5];
        t2_data[0] = 2'b01; t2_data[1] = 2'b10; t2_data[2] = 2'b11;
        t2_data[3] = 2'b00; t2_data[4] = 2'b01;

        rst_n       = 1'b0;
        flush       = 1'b0;
        cfg_chunks  = '0;
        cfg_m       = '0;
        in_valid    = 1'b0;
        xor_product = 2'b00;
        out_ready   = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_reset_vals("reset");

        // three-chunk packets, two parities per stripe
        cfg_chunks = 4'd3;
        cfg_m      = 8'd2;
        in_valid   = 1'b1;
        xor_product = 2'b01; step();
        check("t1_state_run", 32'(dbg_state), 32'(ACC_RUN));
        check("t1_no_out_yet", 32'(out_valid), 32'd0);
        xor_product = 2'b10; step();
        xor_product = 2'b11; step();
        in_valid = 1'b0;
        check_out("t1_p0", 2'b00, 0, 1'b0);
        step();
        check("t1_cleared", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        xor_product = 2'b11; step();
        xor_product = 2'b11; step();
        xor_product = 2'b10; step();
        in_valid = 1'b0;
        check_out("t1_p1", 2'b10, 1, 1'b1);
        step();

        // single-chunk packets, back-to-back, index wraps at m=4
        do_flush();
        cfg_chunks = 4'd1;
        cfg_m      = 8'd4;
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xor_product = t2_data[i];
            step();
            check_out($sformatf("t2_b%0d", i), t2_data[i], i % 4, (i % 4) == 3);
        end
        in_valid = 1'b0;
        step();
        check("t2_drained", 32'(out_valid), 32'd0);

        // output backpressure: last beat stalls, first beat still accumulates
        do_flush();
        cfg_chunks = 4'd2;
        cfg_m      = 8'd4;
        in_valid   = 1'b1;
        xor_product = 2'b01; step();
        xor_product = 2'b10; step();
        check_out("t3_a", 2'b11, 0, 1'b0);
        out_ready   = 1'b0;
        xor_product = 2'b11;
        #1;
        check("t3_first_ready", 32'(in_ready), 32'd1);
        step();
        check_out("t3_hold1", 2'b11, 0, 1'b0);
        check("t3_state_run", 32'(dbg_state), 32'(ACC_RUN));
        xor_product = 2'b01;
        #1;
        check("t3_last_stalled", 32'(in_ready), 32'd0);
        step();
        check_out("t3_hold2", 2'b11, 0, 1'b0);
        check("t3_still_run", 32'(dbg_state), 32'(ACC_RUN));
        out_ready = 1'b1;
        #1;
        check("t3_ready_again", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_out("t3_b", 2'b10, 1, 1'b0);
        step();
        check("t3_drained", 32'(out_valid), 32'd0);

        // cfg_chunks change mid-packet takes effect on the next packet
        do_flush();
        cfg_chunks = 4'd2;
        cfg_m      = 8'd4;
        in_valid   = 1'b1;
        xor_product = 2'b01; step();
        cfg_chunks  = 4'd4;
        xor_product = 2'b10; step();
        check_out("t4_a", 2'b11, 0, 1'b0);
        xor_product = 2'b01; step();
        xor_product = 2'b01; step();
        xor_product = 2'b10; step();
        check("t4_not_done", 32'(out_valid), 32'd0);
        xor_product = 2'b00; step();
        in_valid = 1'b0;
        check_out("t4_b", 2'b10, 1, 1'b0);
        step();

        // flush in ACC_RUN with a pending output; simultaneous beat dropped
        do_flush();
        cfg_chunks = 4'd2;
        cfg_m      = 8'd4;
        in_valid   = 1'b1;
        xor_product = 2'b01; step();
        xor_product = 2'b10; step();
        out_ready   = 1'b0;
        xor_product = 2'b11; step();
        check("t5f_pre_state", 32'(dbg_state), 32'(ACC_RUN));
        check("t5f_pre_valid", 32'(out_valid), 32'd1);
        flush       = 1'b1;
        xor_product = 2'b10;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_vals("t5f");
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        xor_product = 2'b10; step();
        xor_product = 2'b00; step();
        in_valid = 1'b0;
        check_out("t5f_next", 2'b10, 0, 1'b0);
        step();

        // asynchronous reset in ACC_RUN with a pending output
        in_valid    = 1'b1;
        xor_product = 2'b01; step();
        xor_product = 2'b10; step();
        check_out("t5r_pre", 2'b11, 1, 1'b0);
        out_ready   = 1'b0;
        xor_product = 2'b11; step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_vals("t5r");
        step();
        rst_n = 1'b1;
        cfg_chunks  = 4'd2;
        cfg_m       = 8'd4;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        xor_product = 2'b01; step();
        xor_product = 2'b11; step();
        in_valid = 1'b0;
        check_out("t5r_next", 2'b10, 0, 1'b0);
        step();

        // zero config means one chunk per packet and one parity per stripe
        do_flush();
        cfg_chunks = '0;
        cfg_m      = '0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        xor_product = 2'b01; step();
        check_out("t6_b0", 2'b01, 0, 1'b1);
        xor_product = 2'b10; step();
        check_out("t6_b1", 2'b10, 0, 1'b1);
        xor_product = 2'b11; step();
        check_out("t6_b2", 2'b11, 0, 1'b1);
        out_ready   = 1'b0;
        xor_product = 2'b01;
        #1;
        check("t6_stalled", 32'(in_ready), 32'd0);
        step();
        step();
        check_out("t6_hold", 2'b11, 0, 1'b1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_out("t6_b3", 2'b01, 0, 1'b1);
        step();
        check("t6_drained", 32'(out_valid), 32'd0);
`ifdef EC_PARITY_STATS_EN
        check("t6_stat_parity", stat_parity_cnt, 32'd4);
        check("t6_stat_stall", stat_stall_cnt, 32'd2);
        do_flush();
        check("stat_flush_parity", stat_parity_cnt, 32'd0);
        check("stat_flush_stall", stat_stall_cnt, 32'd0);
`endif

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
